fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 16 +
 rtl/next_pc_logic.sv | 30 +++
 rtl/fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 6;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch FSM: request, wait for memory, hold the instruction until retired.
  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StHold
  } state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection for the retiring instruction: jump, taken branch or sequential.
// Jump wins over branch when both are asserted. All arithmetic wraps at 2^32.
module next_pc_logic
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [25:0]     instr_idx_i,
  input  logic            branch_i,
  input  logic            jump_i,
  input  logic            zero_i,
  output logic [XLEN-1:0] next_pc_o
);

  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] branch_target;

  assign jump_target   = {pc_plus4_i[31:28], instr_idx_i, 2'b00};
  assign branch_target = pc_plus4_i + {{14{instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};

  // Priority select of the next fetch address.
  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jump_i) begin
      next_pc_o = jump_target;
    end else if (branch_i && zero_i) begin
      next_pc_o = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests a word at pc, holds it for decode until retired,
// then advances pc via next_pc_logic.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [OP_W-1:0] op_o,
  output logic            instr_valid_o,
  input  logic            retire_i,
  input  logic            branch_i,
  input  logic            jump_i,
  input  logic            zero_i,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     retired_cnt_o,
  output logic [31:0]     stall_cnt_o,
`endif
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            valid_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_logic u_next_pc (
    .pc_plus4_i  (pc_plus4),
    .instr_idx_i (instr_q[25:0]),
    .branch_i    (branch_i),
    .jump_i      (jump_i),
    .zero_i      (zero_i),
    .next_pc_o   (next_pc)
  );

  // Fetch FSM with pc and instruction registers; ready is only looked at while requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch, StWait: begin
          if (imem_ready_i) begin
            instr_q <= imem_rdata_i;
            valid_q <= 1'b1;
            state_q <= StHold;
          end else begin
            state_q <= StWait;
          end
        end
        StHold: begin
          if (retire_i) begin
            pc_q    <= next_pc;
            valid_q <= 1'b0;
            state_q <= StFetch;
          end
        end
        default: begin
          state_q <= StFetch;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gated with rst_n so the request drops the instant reset asserts.
  assign imem_req_o    = rst_n && (state_q != StHold);
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign op_o          = instr_q[31:26];
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt_q;
  logic [31:0] stall_cnt_q;

  // Retire and memory-stall event counters, free-running with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (state_q == StHold && retire_i) begin
        retired_cnt_q <= retired_cnt_q + 32'd1;
      end
      if (state_q == StWait) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign retired_cnt_o = retired_cnt_q;
  assign stall_cnt_o   = stall_cnt_q;
`endif

endmodule
